// File: rtl/desired_drive_pipe.sv
// Assist target-current pipeline: offset-removed torque x cadence x incline x scale,
// five registered stages with an optional per-sample slew limiter on the output.
module desired_drive_pipe #(
    parameter int unsigned TORQ_W     = 12,
    parameter int unsigned TORQUE_MIN = 'h380,
    parameter int unsigned INC_W      = 13,
    parameter int unsigned CUR_W      = 12,
    parameter int unsigned SHIFT      = 15,
    parameter int unsigned SLEW_STEP  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [TORQ_W-1:0] avg_torque,
    input  logic [4:0]        cadence,
    input  logic              not_pedaling,
    input  logic [INC_W-1:0]  incline,
    input  logic [2:0]        scale,
    input  logic              slew_en,
    output logic [CUR_W-1:0]  target_curr,
    output logic              out_vld
);

    localparam int unsigned P1_W   = TORQ_W + 6;
    localparam int unsigned P2_W   = TORQ_W + 15;
    localparam int unsigned PROD_W = TORQ_W + 18;
    localparam logic signed [CUR_W:0] STEP = (CUR_W+1)'(SLEW_STEP);

    logic [TORQ_W-1:0] torque_pos_c;
    logic [5:0]        cad_factor_c;
    logic [INC_W:0]    inc_off_c;
    logic [8:0]        inc_lim_c;

    logic              v0, v1, v2, v3;
    logic [TORQ_W-1:0] s0_torque;
    logic [5:0]        s0_cad;
    logic [8:0]        s0_inc, s1_inc;
    logic [2:0]        s0_scale, s1_scale, s2_scale;
    logic              s0_np, s1_np, s2_np;
    logic [P1_W-1:0]   s1_prod;
    logic [P2_W-1:0]   s2_prod;
    logic [CUR_W-1:0]  s3_raw;

    logic [PROD_W-1:0]       prod3_c;
    logic [CUR_W-1:0]        raw_c;
    logic signed [CUR_W:0]   diff_c;
    logic [CUR_W-1:0]        next_curr_c;

    always_comb begin
        torque_pos_c = '0;
        if (avg_torque > TORQ_W'(TORQUE_MIN))
            torque_pos_c = avg_torque - TORQ_W'(TORQUE_MIN);

        cad_factor_c = '0;
        if (cadence > 5'd1)
            cad_factor_c = {1'b0, cadence} + 6'd32;

        // Saturating to 10b then adding 256 and clipping to 0..511 collapses to one clip.
        inc_off_c = {incline[INC_W-1], incline} + (INC_W+1)'(256);
        if (inc_off_c[INC_W])
            inc_lim_c = '0;
        else if (inc_off_c[INC_W-1:0] > INC_W'(511))
            inc_lim_c = '1;
        else
            inc_lim_c = inc_off_c[8:0];
    end

    always_comb begin
        prod3_c = '0;
        if (!s2_np)
            prod3_c = PROD_W'(s2_prod) * PROD_W'(s2_scale);
        if (|prod3_c[PROD_W-1:SHIFT+CUR_W])
            raw_c = '1;
        else
            raw_c = prod3_c[SHIFT+CUR_W-1:SHIFT];
    end

    always_comb begin
        diff_c      = $signed({1'b0, s3_raw}) - $signed({1'b0, target_curr});
        next_curr_c = s3_raw;
        if (slew_en && (diff_c > STEP))
            next_curr_c = target_curr + CUR_W'(SLEW_STEP);
        else if (slew_en && (diff_c < -STEP))
            next_curr_c = target_curr - CUR_W'(SLEW_STEP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0          <= 1'b0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            v3          <= 1'b0;
            out_vld     <= 1'b0;
            target_curr <= '0;
            s0_torque   <= '0;
            s0_cad      <= '0;
            s0_inc      <= '0;
            s1_inc      <= '0;
            s0_scale    <= '0;
            s1_scale    <= '0;
            s2_scale    <= '0;
            s0_np       <= 1'b0;
            s1_np       <= 1'b0;
            s2_np       <= 1'b0;
            s1_prod     <= '0;
            s2_prod     <= '0;
            s3_raw      <= '0;
        end else begin
            v0      <= in_vld;
            v1      <= v0;
            v2      <= v1;
            v3      <= v2;
            out_vld <= v3;
            if (in_vld) begin
                s0_torque <= torque_pos_c;
                s0_cad    <= cad_factor_c;
                s0_inc    <= inc_lim_c;
                s0_scale  <= scale;
                s0_np     <= not_pedaling;
            end
            if (v0) begin
                s1_prod  <= P1_W'(s0_torque) * P1_W'(s0_cad);
                s1_inc   <= s0_inc;
                s1_scale <= s0_scale;
                s1_np    <= s0_np;
            end
            if (v1) begin
                s2_prod  <= P2_W'(s1_prod) * P2_W'(s1_inc);
                s2_scale <= s1_scale;
                s2_np    <= s1_np;
            end
            if (v2)
                s3_raw <= raw_c;
            if (v3)
                target_curr <= next_curr_c;
        end
    end

endmodule
